enc_bin2onehot_pipe: RTL and testbench

Parametrised, pipelined binary-to-one-hot/thermometer encoder with valid/ready flow control on both sides. Each accepted binary code is encoded, tagged with a range-error flag and held in a 2-entry output buffer until the downstream consumer takes it. The block sits between a code producer (arbiter grant index, address decode) and consumers that need one-hot select or thermometer mask vectors under backpressure.

---
 rtl/enc_bin2onehot_pipe.sv | 101 ++++++++++
 tb/tb_enc_bin2onehot_pipe.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/enc_bin2onehot_pipe.sv
// Binary-to-one-hot/thermometer encoder with a 2-entry valid/ready output buffer.
// Codes >= OUT_W store an all-zero word tagged with an error bit and set a sticky flag.
module enc_bin2onehot_pipe #(
  parameter int IN_W  = 4,
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out,
  output logic             out_err,
  output logic             err_sticky,
  input  logic             clr_err
);

  logic [1:0]       count_q, count_d;
  logic [OUT_W-1:0] word_q [2];
  logic [OUT_W-1:0] word_d [2];
  logic [1:0]       err_q, err_d;
  logic             err_sticky_q, err_sticky_d;

  logic             push, pop;
  logic [31:0]      code;
  logic [OUT_W-1:0] enc_word;
  logic             enc_err;
  logic [1:0]       wr_base;

  assign code      = 32'(in);
  assign in_ready  = (count_q < 2'd2) && !rst;
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign out        = out_valid ? word_q[0] : '0;
  assign out_err    = out_valid && err_q[0];
  assign err_sticky = err_sticky_q;

  always_comb begin
    enc_err  = (code >= 32'(OUT_W));
    enc_word = '0;
    for (int i = 0; i < OUT_W; i++) begin
      enc_word[i] = !enc_err && (in_mode ? (32'(i) <= code) : (32'(i) == code));
    end
  end

  // Slot 0 is always the head; a pop shifts slot 1 down before the new entry lands.
  always_comb begin
    word_d       = word_q;
    err_d        = err_q;
    count_d      = count_q;
    err_sticky_d = err_sticky_q;
    wr_base      = count_q - {1'b0, pop};

    if (pop) begin
      word_d[0] = word_q[1];
      err_d[0]  = err_q[1];
      word_d[1] = '0;
      err_d[1]  = 1'b0;
    end

    if (push) begin
      if (wr_base == 2'd0) begin
        word_d[0] = enc_word;
        err_d[0]  = enc_err;
      end else begin
        word_d[1] = enc_word;
        err_d[1]  = enc_err;
      end
    end

    count_d = count_q + {1'b0, push} - {1'b0, pop};

    if (push && enc_err) begin
      err_sticky_d = 1'b1;
    end else if (clr_err) begin
      err_sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q      <= 2'd0;
      word_q[0]    <= '0;
      word_q[1]    <= '0;
      err_q        <= 2'b00;
      err_sticky_q <= 1'b0;
    end else begin
      count_q      <= count_d;
      word_q[0]    <= word_d[0];
      word_q[1]    <= word_d[1];
      err_q        <= err_d;
      err_sticky_q <= err_sticky_d;
    end
  end

endmodule

// File: tb/tb_enc_bin2onehot_pipe.sv
// Bench for enc_bin2onehot_pipe: OUT_W=16 and OUT_W=12 instances share one stimulus stream,
// each checked every cycle against a queue model plus directed literal expectations.
module tb_enc_bin2onehot_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [3:0]  in_code;
  logic        in_mode;
  logic        out_ready;
  logic        clr_err;

  logic        in_ready16, out_valid16, out_err16, err_sticky16;
  logic [15:0] out16;
  logic        in_ready12, out_valid12, out_err12, err_sticky12;
  logic [11:0] out12;

  int vectors     = 0;
  int miscompares = 0;

  logic [16:0] q16 [$];
  logic [16:0] q12 [$];
  logic        st16 = 1'b0;
  logic        st12 = 1'b0;

  always #5 clk = ~clk;

  enc_bin2onehot_pipe #(.IN_W(4), .OUT_W(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16),
    .in(in_code), .in_mode(in_mode), .out_valid(out_valid16), .out_ready(out_ready),
    .out(out16), .out_err(out_err16), .err_sticky(err_sticky16), .clr_err(clr_err)
  );

  enc_bin2onehot_pipe #(.IN_W(4), .OUT_W(12)) dut12 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready12),
    .in(in_code), .in_mode(in_mode), .out_valid(out_valid12), .out_ready(out_ready),
    .out(out12), .out_err(out_err12), .err_sticky(err_sticky12), .clr_err(clr_err)
  );

  function automatic logic [15:0] enc(input int c, input bit mode, input int w);
    logic [31:0] v;
    if (c >= w) return 16'h0;
    v = mode ? ((32'd2 << c) - 32'd1) : (32'd1 << c);
    return v[15:0];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit v, input int c, input bit mode, input bit ordy, input bit clr);
    in_valid  = v;
    in_code   = 4'(c);
    in_mode   = mode;
    out_ready = ordy;
    clr_err   = clr;
    @(posedge clk);
    #1;
  endtask

  // Model steps on each rising edge, then both DUTs are compared on the falling edge.
  initial begin : model_and_compare
    bit push, pop;
    int c;
    logic [16:0] h;
    forever begin
      @(posedge clk);
      c = int'(in_code);
      if (rst) begin
        q16.delete(); q12.delete();
        st16 = 1'b0; st12 = 1'b0;
      end else begin
        push = in_valid && (q16.size() < 2);
        pop  = out_ready && (q16.size() > 0);
        if (pop) void'(q16.pop_front());
        if (push) q16.push_back({c >= 16, enc(c, in_mode, 16)});
        st16 = (push && c >= 16) ? 1'b1 : (clr_err ? 1'b0 : st16);

        push = in_valid && (q12.size() < 2);
        pop  = out_ready && (q12.size() > 0);
        if (pop) void'(q12.pop_front());
        if (push) q12.push_back({c >= 12, enc(c, in_mode, 12)});
        st12 = (push && c >= 12) ? 1'b1 : (clr_err ? 1'b0 : st12);
      end
      @(negedge clk);
      h = (q16.size() > 0) ? q16[0] : 17'h0;
      checkOutput("valid16", 32'(out_valid16), 32'(q16.size() > 0));
      checkOutput("out16", 32'(out16), 32'(h[15:0]));
      checkOutput("err16", 32'(out_err16), 32'(h[16]));
      checkOutput("sticky16", 32'(err_sticky16), 32'(st16));
      checkOutput("in_ready16", 32'(in_ready16), 32'(!rst && q16.size() < 2));
      h = (q12.size() > 0) ? q12[0] : 17'h0;
      checkOutput("valid12", 32'(out_valid12), 32'(q12.size() > 0));
      checkOutput("out12", 32'(out12), 32'(h[11:0]));
      checkOutput("err12", 32'(out_err12), 32'(h[16]));
      checkOutput("sticky12", 32'(err_sticky12), 32'(st12));
      checkOutput("in_ready12", 32'(in_ready12), 32'(!rst && q12.size() < 2));
    end
  end

  initial begin : stimulus
    rst = 1'b1; in_valid = 1'b0; in_code = 4'd0; in_mode = 1'b0;
    out_ready = 1'b0; clr_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_valid", 32'(out_valid16), 32'h0);
    checkOutput("rst_out", 32'(out16), 32'h0);
    checkOutput("rst_sticky", 32'(err_sticky16), 32'h0);
    checkOutput("rst_in_ready", 32'(in_ready16), 32'h0);
    rst = 1'b0;
    #1;
    checkOutput("post_rst_in_ready", 32'(in_ready16), 32'h1);

    for (int c = 0; c < 16; c++) begin
      applyStimulus(1'b1, c, 1'b0, 1'b1, 1'b0);
      checkOutput("sweep_out", 32'(out16), 32'h1 << c);
      checkOutput("sweep_valid", 32'(out_valid16), 32'h1);
    end
    checkOutput("sweep_sticky", 32'(err_sticky16), 32'h0);

    applyStimulus(1'b1, 0, 1'b1, 1'b1, 1'b0);
    checkOutput("therm0", 32'(out16), 32'h0001);
    applyStimulus(1'b1, 5, 1'b1, 1'b1, 1'b0);
    checkOutput("therm5", 32'(out16), 32'h003F);
    applyStimulus(1'b1, 15, 1'b1, 1'b1, 1'b0);
    checkOutput("therm15", 32'(out16), 32'hFFFF);

    applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b1);
    checkOutput("pre_range_sticky12", 32'(err_sticky12), 32'h0);
    applyStimulus(1'b1, 13, 1'b0, 1'b1, 1'b0);
    checkOutput("range_out12", 32'(out12), 32'h000);
    checkOutput("range_err12", 32'(out_err12), 32'h1);
    checkOutput("range_sticky12", 32'(err_sticky12), 32'h1);
    checkOutput("range_out16", 32'(out16), 32'h2000);
    applyStimulus(1'b1, 14, 1'b0, 1'b1, 1'b1);
    checkOutput("set_beats_clr", 32'(err_sticky12), 32'h1);
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b1);
    checkOutput("clr_alone", 32'(err_sticky12), 32'h0);

    applyStimulus(1'b1, 2, 1'b0, 1'b0, 1'b0);
    checkOutput("bp_ready_one", 32'(in_ready16), 32'h1);
    applyStimulus(1'b1, 3, 1'b0, 1'b0, 1'b0);
    checkOutput("bp_ready_full", 32'(in_ready16), 32'h0);
    checkOutput("bp_head", 32'(out16), 32'h0004);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 7, 1'b0, 1'b0, 1'b0);
      checkOutput("bp_hold", 32'(out16), 32'h0004);
    end
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b0);
    checkOutput("bp_second", 32'(out16), 32'h0008);
    checkOutput("bp_ready_back", 32'(in_ready16), 32'h1);
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b0);
    checkOutput("bp_empty", 32'(out_valid16), 32'h0);

    applyStimulus(1'b1, 13, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1, 1'b0, 1'b0, 1'b0);
    checkOutput("pre_rst_sticky12", 32'(err_sticky12), 32'h1);
    checkOutput("pre_rst_full12", 32'(in_ready12), 32'h0);
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    checkOutput("mid_rst_in_ready", 32'(in_ready12), 32'h0);
    @(posedge clk);
    #1;
    checkOutput("mid_rst_valid", 32'(out_valid12), 32'h0);
    checkOutput("mid_rst_out", 32'(out12), 32'h0);
    checkOutput("mid_rst_sticky", 32'(err_sticky12), 32'h0);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    checkOutput("after_rst_in_ready", 32'(in_ready12), 32'h1);

    repeat (3) applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
